hrange_pairs: RTL and testbench

- Generator-style caller that sits directly downstream of an `hrange` instance.
- It launches the callee with `(base, limit, step)`, consumes the callee's stream over ready/valid, and for every pair of consecutive callee values `(prev, cur)` yields the tuple `(prev, cur, prev+cur)`.
- Python model:
  `def hrange_pairs(base, limit, step): prev = None; for i in hrange(base, limit, step): if prev is not None: yield prev, i, prev + i; prev = i`
- Its own caller-facing interface uses the same start/ready/valid/done protocol as every generator module.

---
 rtl/hrange_pairs_if.sv | 42 ++++
 rtl/hrange_pairs.sv | 132 +++++++++++++
 tb/tb_hrange_pairs.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/hrange_pairs_if.sv
// Bundle of caller-facing generator handshake and callee (hrange) handshake for hrange_pairs.
// The slave modport is the hrange_pairs side; master is whoever drives it and models the callee.
interface hrange_pairs_if;
    // Caller-facing generator protocol
    logic               _start;
    logic signed [31:0] base;
    logic signed [31:0] limit;
    logic signed [31:0] step;
    logic               _ready;
    logic               _valid;
    logic               _done;
    logic signed [31:0] _0;
    logic signed [31:0] _1;
    logic signed [31:0] _2;

    // Callee (hrange) launch and stream
    logic signed [31:0] _hrange_base;
    logic signed [31:0] _hrange_limit;
    logic signed [31:0] _hrange_step;
    logic               _hrange_start;
    logic               _hrange_reset;
    logic               _hrange_ready;
    logic               _hrange_valid;
    logic               _hrange_done;
    logic signed [31:0] _hrange_0;

    modport slave (
        input  _start, base, limit, step, _ready,
        input  _hrange_valid, _hrange_done, _hrange_0,
        output _valid, _done, _0, _1, _2,
        output _hrange_base, _hrange_limit, _hrange_step,
        output _hrange_start, _hrange_reset, _hrange_ready
    );

    modport master (
        output _start, base, limit, step, _ready,
        output _hrange_valid, _hrange_done, _hrange_0,
        input  _valid, _done, _0, _1, _2,
        input  _hrange_base, _hrange_limit, _hrange_step,
        input  _hrange_start, _hrange_reset, _hrange_ready
    );
endinterface

// File: rtl/hrange_pairs.sv
// Generator that launches an hrange callee and yields (prev, cur, prev+cur) for every pair of
// consecutive callee values.
module hrange_pairs (
    input logic           _clock,
    input logic           _reset,
    hrange_pairs_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StLaunch, StFirst, StStream} state_e;

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic signed [31:0] out0_q, out0_d;
    logic signed [31:0] out1_q, out1_d;
    logic signed [31:0] out2_q, out2_d;
    logic signed [31:0] prev_q, prev_d;
    logic signed [31:0] hr_base_q, hr_base_d;
    logic signed [31:0] hr_limit_q, hr_limit_d;
    logic signed [31:0] hr_step_q, hr_step_d;
    logic               hr_start_q, hr_start_d;
    logic               hr_reset_q;
    logic               hr_ready;
    logic               advance;
    logic signed [31:0] sum;

    // A held tuple blocks the callee until downstream takes it.
    assign advance = bus._ready || !valid_q;
    assign sum     = prev_q + bus._hrange_0;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        out0_d     = out0_q;
        out1_d     = out1_q;
        out2_d     = out2_q;
        prev_d     = prev_q;
        hr_base_d  = hr_base_q;
        hr_limit_d = hr_limit_q;
        hr_step_d  = hr_step_q;
        hr_start_d = 1'b0;
        hr_ready   = 1'b0;

        if (bus._ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
            end
            // Callee outputs are stale here (it has not seen the start yet), so ignore them.
            StLaunch: begin
                state_d = StFirst;
            end
            StFirst: begin
                hr_ready = 1'b1;
                if (bus._hrange_valid) begin
                    prev_d  = bus._hrange_0;
                    state_d = StStream;
                end else if (bus._hrange_done) begin
                    state_d = StIdle;
                end
            end
            StStream: begin
                hr_ready = advance;
                if (advance) begin
                    if (bus._hrange_valid) begin
                        out0_d  = prev_q;
                        out1_d  = bus._hrange_0;
                        out2_d  = sum;
                        valid_d = 1'b1;
                        prev_d  = bus._hrange_0;
                    end else if (bus._hrange_done) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (bus._start) begin
            hr_base_d  = bus.base;
            hr_limit_d = bus.limit;
            hr_step_d  = bus.step;
            hr_start_d = 1'b1;
            valid_d    = 1'b0;
            state_d    = StLaunch;
        end
    end

    // Start overrides reset so a restart can be issued while resetting.
    always_ff @(posedge _clock) begin
        hr_reset_q <= _reset;
        if (_reset && !bus._start) begin
            state_q    <= StIdle;
            valid_q    <= 1'b0;
            out0_q     <= '0;
            out1_q     <= '0;
            out2_q     <= '0;
            prev_q     <= '0;
            hr_base_q  <= '0;
            hr_limit_q <= '0;
            hr_step_q  <= '0;
            hr_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            out0_q     <= out0_d;
            out1_q     <= out1_d;
            out2_q     <= out2_d;
            prev_q     <= prev_d;
            hr_base_q  <= hr_base_d;
            hr_limit_q <= hr_limit_d;
            hr_step_q  <= hr_step_d;
            hr_start_q <= hr_start_d;
        end
    end

    assign bus._valid        = valid_q;
    assign bus._done         = (state_q == StIdle);
    assign bus._0            = out0_q;
    assign bus._1            = out1_q;
    assign bus._2            = out2_q;
    assign bus._hrange_base  = hr_base_q;
    assign bus._hrange_limit = hr_limit_q;
    assign bus._hrange_step  = hr_step_q;
    assign bus._hrange_start = hr_start_q;
    assign bus._hrange_reset = hr_reset_q;
    assign bus._hrange_ready = hr_ready;

endmodule

// File: tb/tb_hrange_pairs.sv
// Bench for hrange_pairs: a queue-based hrange callee feeds the DUT, and expected tuples are
// derived from the range list with plain arithmetic.
module tb_hrange_pairs;

    typedef int int_q_t[$];

    logic clk = 1'b0;
    logic rst;
    bit   gaps = 1'b0;
    bit   stall;
    int   total = 0;
    int   bad = 0;
    int   cq[$];

    hrange_pairs_if bus ();

    hrange_pairs dut (
        ._clock (clk),
        ._reset (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Python range(b, l, s) semantics, capped to keep runs short.
    function automatic int_q_t hrange_vals(input int b, input int l, input int s);
        int_q_t v;
        int     x;
        x = b;
        if (s != 0) begin
            while (((s > 0) ? (x < l) : (x > l)) && v.size() < 64) begin
                v.push_back(x);
                x += s;
            end
        end
        return v;
    endfunction

    // Callee: registered outputs; start wins over reset; optional random bubbles.
    always @(posedge clk) begin
        if (bus._hrange_start === 1'b1) begin
            cq = hrange_vals(bus._hrange_base, bus._hrange_limit, bus._hrange_step);
        end else if (bus._hrange_reset === 1'b1) begin
            cq.delete();
        end else if (bus._hrange_ready === 1'b1 && bus._hrange_valid === 1'b1 && cq.size() > 0) begin
            void'(cq.pop_front());
        end
        stall = gaps && ($urandom_range(0, 2) == 0);
        bus._hrange_valid <= (cq.size() > 0) && !stall;
        bus._hrange_done  <= (cq.size() == 0);
        if (cq.size() > 0) bus._hrange_0 <= cq[0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // mode: 0 always ready, 1 random ready, 2 hold the 2nd tuple for 3 cycles.
    task automatic run(input int b, input int l, input int s, input int mode, input int abort_at,
                       input bit with_rst, input bit chk_lat);
        int_q_t      vals;
        int          n_tup;
        int          idx;
        int          edges;
        int          first_v;
        int          held;
        bit          finished;
        bit          aborted;
        logic [31:0] e0, e1, e2;

        vals     = hrange_vals(b, l, s);
        n_tup    = (vals.size() > 1) ? vals.size() - 1 : 0;
        idx      = 0;
        edges    = 1;
        first_v  = -1;
        held     = 0;
        finished = 1'b0;
        aborted  = 1'b0;

        bus._start = 1'b1;
        bus.base   = b;
        bus.limit  = l;
        bus.step   = s;
        rst        = with_rst;
        @(negedge clk);
        bus._start = 1'b0;
        rst        = 1'b0;
        chk_b("launch_hr_start", bus._hrange_start, 1'b1);
        chk("launch_hr_base", bus._hrange_base, b);
        chk("launch_hr_limit", bus._hrange_limit, l);
        chk("launch_hr_step", bus._hrange_step, s);
        chk_b("launch_hr_ready", bus._hrange_ready, 1'b0);
        chk_b("launch_valid", bus._valid, 1'b0);
        chk_b("launch_done", bus._done, 1'b0);
        chk_b("launch_hr_reset", bus._hrange_reset, with_rst);

        for (int c = 0; c < 400 && !finished && !aborted; c++) begin
            @(negedge clk);
            edges++;
            if (c == 0) chk_b("start_pulse_len", bus._hrange_start, 1'b0);
            if (bus._valid === 1'b1) begin
                if (first_v < 0) first_v = edges;
                chk_b("no_extra_tuple", (idx < n_tup), 1'b1);
                if (idx < n_tup) begin
                    e0 = vals[idx];
                    e1 = vals[idx + 1];
                    e2 = vals[idx] + vals[idx + 1];
                    chk("tuple_prev", bus._0, e0);
                    chk("tuple_cur", bus._1, e1);
                    chk("tuple_sum", bus._2, e2);
                end
            end
            if (bus._done === 1'b1) begin
                chk_b("done_without_valid", bus._valid, 1'b0);
                finished = 1'b1;
            end else begin
                case (mode)
                    1: bus._ready = ($urandom_range(0, 1) == 1);
                    2: begin
                        if (bus._valid === 1'b1 && idx == 1 && held < 3) begin
                            bus._ready = 1'b0;
                            held++;
                        end else begin
                            bus._ready = 1'b1;
                        end
                    end
                    default: bus._ready = 1'b1;
                endcase
                #1;
                if (bus._valid === 1'b1 && !bus._ready) begin
                    chk_b("stall_hr_ready", bus._hrange_ready, 1'b0);
                end
                if (bus._valid === 1'b1 && bus._ready) begin
                    idx++;
                    if (abort_at > 0 && idx == abort_at) aborted = 1'b1;
                end
            end
        end

        if (aborted) begin
            @(negedge clk);
        end else begin
            chk_b("finished_in_budget", finished, 1'b1);
            chk("tuple_count", idx, n_tup);
            if (chk_lat) chk("first_valid_edge", first_v, 4);
            if (mode == 2) chk("held_cycles", held, 3);
            bus._ready = 1'b0;
            @(negedge clk);
            chk_b("idle_done", bus._done, 1'b1);
            chk_b("idle_valid", bus._valid, 1'b0);
        end
    endtask

    initial begin
        int rb, rl, rs;
        rst        = 1'b1;
        bus._start = 1'b0;
        bus._ready = 1'b0;
        bus.base   = '0;
        bus.limit  = '0;
        bus.step   = '0;

        repeat (2) @(negedge clk);
        chk_b("rst_valid", bus._valid, 1'b0);
        chk_b("rst_done", bus._done, 1'b1);
        chk_b("rst_hr_start", bus._hrange_start, 1'b0);
        chk_b("rst_hr_ready", bus._hrange_ready, 1'b0);
        chk_b("rst_hr_reset", bus._hrange_reset, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk_b("post_rst_hr_reset", bus._hrange_reset, 1'b0);
        chk_b("post_rst_done", bus._done, 1'b1);

        // Basic stream with latency check, then N=1 and N=0.
        run(0, 10, 2, 0, 0, 1'b0, 1'b1);
        run(0, 1, 1, 0, 0, 1'b0, 1'b0);
        run(5, 5, 1, 0, 0, 1'b0, 1'b0);

        // Backpressure on (2,4,6).
        run(0, 10, 2, 2, 0, 1'b0, 1'b0);

        // Sum wraps negative.
        run(32'h4000_0000, 32'h4000_0002, 1, 0, 0, 1'b0, 1'b0);

        // Reset after the 2nd tuple, then a fresh run.
        run(0, 10, 2, 0, 2, 1'b0, 1'b0);
        rst        = 1'b1;
        bus._ready = 1'b0;
        @(negedge clk);
        chk_b("midrst_valid", bus._valid, 1'b0);
        chk_b("midrst_hr_reset", bus._hrange_reset, 1'b1);
        chk_b("midrst_done", bus._done, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk_b("midrst_hr_reset_drop", bus._hrange_reset, 1'b0);
        chk_b("midrst_idle_done", bus._done, 1'b1);
        run(0, 6, 3, 0, 0, 1'b0, 1'b0);

        // Start together with reset mid-stream: restart wins.
        run(0, 20, 1, 0, 3, 1'b0, 1'b0);
        run(0, 10, 2, 0, 0, 1'b1, 1'b0);

        // Randomized runs with callee bubbles and random downstream ready.
        gaps = 1'b1;
        repeat (10) begin
            rb = int'($urandom_range(0, 40)) - 20;
            rs = int'($urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) rs = -rs;
            rl = rb + int'($urandom_range(0, 40)) - 15;
            run(rb, rl, rs, 1, 0, 1'b0, 1'b0);
        end
        gaps = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
